// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the issue-side hazard scoreboard: register index type,
// producer age constants and the per-register scoreboard entry.
package hazard_scoreboard_pkg;

   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned AGE_BITS = 2;

   typedef logic [4:0]          reg_idx_t;
   typedef logic [AGE_BITS-1:0] age_t;

   // Stage currently holding the youngest producer of a register.
   localparam age_t AGE_EX  = 2'd0;
   localparam age_t AGE_MEM = 2'd1;
   localparam age_t AGE_WB  = 2'd2;

   typedef struct packed {
      logic busy;
      logic is_load;
      age_t age;
   } sb_entry_t;

endpackage

// File: rtl/scoreboard_entry.sv
// One scoreboard entry: tracks the youngest in-flight writer of a single register as it
// moves EX -> MEM -> WB, holding still while the pipeline is frozen.
module scoreboard_entry
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned AGE_W = 2
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      advance_i,
   input  logic      set_i,
   input  logic      set_load_i,
   output sb_entry_t entry_o
);

   logic             busy_q, busy_d;
   logic             load_q, load_d;
   logic [AGE_W-1:0] age_q, age_d;

   always_comb begin
      busy_d = busy_q;
      load_d = load_q;
      age_d  = age_q;
      if (advance_i) begin
         // A new issue takes priority over the expiry of an older producer.
         if (set_i) begin
            busy_d = 1'b1;
            load_d = set_load_i;
            age_d  = AGE_W'(AGE_EX);
         end else if (busy_q) begin
            if (age_q == AGE_W'(AGE_WB)) begin
               busy_d = 1'b0;
               load_d = 1'b0;
               age_d  = AGE_W'(AGE_EX);
            end else if (age_q == AGE_W'(AGE_MEM)) begin
               age_d = AGE_W'(AGE_WB);
            end else begin
               age_d = AGE_W'(AGE_MEM);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         busy_q <= 1'b0;
         load_q <= 1'b0;
         age_q  <= '0;
      end else begin
         busy_q <= busy_d;
         load_q <= load_d;
         age_q  <= age_d;
      end
   end

   assign entry_o = '{busy: busy_q, is_load: load_q, age: age_t'(age_q)};

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-side hazard tracker: records in-flight register writes and raises the load-use stall.
// Optional HAZARD_SCOREBOARD_PERF_EN adds a saturating stall-cycle counter (stall_count_o).
module hazard_scoreboard #(
   parameter int unsigned NUM_REGS = hazard_scoreboard_pkg::NUM_REGS,
   parameter int unsigned AGE_W    = hazard_scoreboard_pkg::AGE_BITS
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            id_valid_i,
   input  hazard_scoreboard_pkg::reg_idx_t id_rs1_i,
   input  hazard_scoreboard_pkg::reg_idx_t id_rs2_i,
   input  logic                            id_rs1_used_i,
   input  logic                            id_rs2_used_i,
   input  hazard_scoreboard_pkg::reg_idx_t id_rd_i,
   input  logic                            id_reg_write_i,
   input  logic                            id_is_load_i,
   input  logic                            flush_i,
   input  logic                            mem_wait_i,
   output logic                            stall_o,
   output logic [NUM_REGS-1:0]             busy_o
`ifdef HAZARD_SCOREBOARD_PERF_EN
   ,
   output logic [31:0]                     stall_count_o
`endif
);

   import hazard_scoreboard_pkg::*;

   sb_entry_t entries [NUM_REGS];
   logic      issue;
   logic      wr_en;
   logic      hit1, hit2;

   assign issue = id_valid_i & ~stall_o & ~flush_i & ~mem_wait_i;
   assign wr_en = issue & id_reg_write_i & (id_rd_i != '0);

   // x0 is hardwired and never gets an entry.
   assign entries[0] = '0;
   assign busy_o[0]  = 1'b0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
      scoreboard_entry #(
         .AGE_W(AGE_W)
      ) u_entry (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .advance_i (~mem_wait_i),
         .set_i     (wr_en && (id_rd_i == reg_idx_t'(r))),
         .set_load_i(id_is_load_i),
         .entry_o   (entries[r])
      );
      assign busy_o[r] = entries[r].busy;
   end

   // Only a load still in EX cannot be forwarded to the ID-stage consumer.
   assign hit1 = id_rs1_used_i && (id_rs1_i != '0) && entries[id_rs1_i].busy &&
                 entries[id_rs1_i].is_load && (entries[id_rs1_i].age == AGE_EX);
   assign hit2 = id_rs2_used_i && (id_rs2_i != '0) && entries[id_rs2_i].busy &&
                 entries[id_rs2_i].is_load && (entries[id_rs2_i].age == AGE_EX);

   assign stall_o = id_valid_i & ~flush_i & (hit1 | hit2);

`ifdef HAZARD_SCOREBOARD_PERF_EN
   logic [31:0] stall_count_q, stall_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall_o && !mem_wait_i && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count_o = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed hazards plus random traffic against a
// pipeline-slot reference model; expectations queued and checked by a separate monitor.
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, rs1_used, rs2_used, reg_write, is_load, flush, mem_wait;
   logic [4:0]  rs1, rs2, rd;
   logic        stall;
   logic [31:0] busy;
`ifdef HAZARD_SCOREBOARD_PERF_EN
   logic [31:0] stall_count;
`endif

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk_i         (clk),
      .rst_i         (rst_n),
      .id_valid_i    (id_valid),
      .id_rs1_i      (rs1),
      .id_rs2_i      (rs2),
      .id_rs1_used_i (rs1_used),
      .id_rs2_used_i (rs2_used),
      .id_rd_i       (rd),
      .id_reg_write_i(reg_write),
      .id_is_load_i  (is_load),
      .flush_i       (flush),
      .mem_wait_i    (mem_wait),
      .stall_o       (stall),
      .busy_o        (busy)
`ifdef HAZARD_SCOREBOARD_PERF_EN
      ,
      .stall_count_o (stall_count)
`endif
   );

   typedef struct {
      bit valid; int rd; bit we; bit ld;
      int rs1; bit u1; int rs2; bit u2;
      bit flush; bit mw;
   } stim_t;

   // Reference model: contents of the EX, MEM and WB stages (v = holds a register writer).
   typedef struct { bit v; int rd; bit ld; } slot_t;
   typedef struct { string tag; bit stall; logic [31:0] busy; } exp_t;

   slot_t m_ex, m_mem, m_wb;
   exp_t  q[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   int    model_stalls = 0;

   function automatic stim_t mk(bit valid, int rd_, bit we, bit ld, int r1, bit u1, int r2,
                                bit u2, bit fl, bit mw);
      stim_t s;
      s.valid = valid; s.rd = rd_; s.we = we; s.ld = ld;
      s.rs1 = r1; s.u1 = u1; s.rs2 = r2; s.u2 = u2; s.flush = fl; s.mw = mw;
      return s;
   endfunction

   function automatic stim_t nop();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic stim_t lw(int rd_);
      return mk(1, rd_, 1, 1, 1, 1, 0, 0, 0, 0);
   endfunction

   function automatic stim_t alu(int rd_, int r1, int r2);
      return mk(1, rd_, 1, 0, r1, 1, r2, 1, 0, 0);
   endfunction

   function automatic logic [31:0] model_busy();
      logic [31:0] b = '0;
      for (int r = 1; r < 32; r++) begin
         b[r] = (m_ex.v && m_ex.rd == r) || (m_mem.v && m_mem.rd == r) ||
                (m_wb.v && m_wb.rd == r);
      end
      return b;
   endfunction

   function automatic bit model_stall(stim_t s);
      bit h1 = s.u1 && s.rs1 != 0 && m_ex.v && m_ex.ld && m_ex.rd == s.rs1;
      bit h2 = s.u2 && s.rs2 != 0 && m_ex.v && m_ex.ld && m_ex.rd == s.rs2;
      return s.valid && !s.flush && (h1 || h2);
   endfunction

   function automatic void model_reset();
      m_ex = '{0, 0, 0}; m_mem = '{0, 0, 0}; m_wb = '{0, 0, 0};
      model_stalls = 0;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic drive(stim_t s);
      id_valid  = s.valid;
      rd        = s.rd[4:0];
      reg_write = s.we;
      is_load   = s.ld;
      rs1       = s.rs1[4:0];
      rs1_used  = s.u1;
      rs2       = s.rs2[4:0];
      rs2_used  = s.u2;
      flush     = s.flush;
      mem_wait  = s.mw;
   endtask

   task automatic step(string tag, stim_t s);
      exp_t e;
      bit   issue;
      @(negedge clk);
      drive(s);
      e.tag   = tag;
      e.stall = model_stall(s);
      e.busy  = model_busy();
      q.push_back(e);
      @(posedge clk);
      if (!s.mw) begin
         if (e.stall) model_stalls++;
         issue = s.valid && !e.stall && !s.flush;
         m_wb  = m_mem;
         m_mem = m_ex;
         if (issue && s.we && s.rd != 0) m_ex = '{1, s.rd, s.ld};
         else m_ex = '{0, 0, 0};
      end
   endtask

   // Monitor: compares the DUT against each queued expectation mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (q.size() != 0) begin
            e = q.pop_front();
            check({e.tag, "_stall"}, {31'b0, stall}, {31'b0, e.stall});
            check({e.tag, "_busy"}, busy, e.busy);
         end
      end
   end

   initial begin
      stim_t s;
      model_reset();
      drive(nop());
      rst_n = 1'b0;
      #2;
      check("reset_busy", busy, 32'h0);
      check("reset_stall", {31'b0, stall}, 32'h0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      // Load-use: exactly one stall, busy clears after three stages.
      step("lu_lw", lw(5));
      step("lu_use", alu(6, 5, 1));
      step("lu_use2", alu(6, 5, 1));
      repeat (4) step("lu_tail", nop());

      // ALU producer: forwarding covers it.
      step("alu_add", alu(5, 2, 3));
      step("alu_sub", alu(7, 5, 5));
      repeat (3) step("alu_tail", nop());

      // x0 and unused sources.
      step("x0_lw", lw(0));
      step("x0_use", alu(8, 0, 0));
      step("unused_lw", lw(5));
      step("unused_use", mk(1, 9, 1, 0, 5, 0, 0, 0, 0, 0));
      repeat (3) step("unused_tail", nop());

      // Freeze holds the load in EX; stall persists then releases after one more cycle.
      step("frz_lw", lw(5));
      s = alu(6, 1, 5);
      s.mw = 1;
      repeat (3) step("frz_hold", s);
      s.mw = 0;
      step("frz_rel", s);
      step("frz_go", s);
      repeat (3) step("frz_tail", nop());

      // WAW: youngest producer (non-load) wins.
      step("waw_lw", lw(5));
      step("waw_add", alu(5, 1, 2));
      step("waw_use", alu(6, 5, 5));
      repeat (3) step("waw_tail", nop());

      // Flushed load never enters the scoreboard.
      s = lw(9);
      s.flush = 1;
      step("flush_lw", s);
      repeat (2) step("flush_tail", nop());

      // Asynchronous reset in the middle of a stall.
      step("rst_lw", lw(5));
      @(negedge clk);
      drive(alu(6, 5, 0));
      #1;
      check("pre_reset_stall", {31'b0, stall}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("async_reset_stall", {31'b0, stall}, 32'h0);
      check("async_reset_busy", busy, 32'h0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      drive(nop());
      rst_n = 1'b1;

      // Random traffic over a small register window to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         s = mk($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                $urandom_range(0, 9) < 4, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 9) == 0,
                $urandom_range(0, 4) == 0);
         step("rand", s);
      end
      step("end", nop());

      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      #5;
      if (q.size() != 0) check("drain_timeout", q.size(), 32'h0);

`ifdef HAZARD_SCOREBOARD_PERF_EN
      check("stall_count", stall_count, model_stalls);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
